// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART transmit scheduler
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// rtl/uart_rr_arb2.sv - two-input round-robin picker, combinational
module uart_rr_arb2
    import uart_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic id
);

    always_comb begin
        valid = req0 | req1;
        // On contention the channel that did not win last time goes next.
        if (req0 && req1) begin
            id = ~last;
        end else if (req1) begin
            id = CH1;
        end else begin
            id = CH0;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART Tx unit between two byte requesters
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              grant_id,
    output logic              err_timeout,
    input  logic              clr_err
);

    localparam int               CNT_W    = $clog2(max3(BUSY_TIMEOUT, GAP_CYCLES, 2));
    localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]       ST_POST  = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic             arb_valid;
    logic             arb_id;
    logic             grant;

    uart_rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
        .last  (grant_id),
        .valid (arb_valid),
        .id    (arb_id)
    );

    assign cnt_inc = cnt + CNT_W'(1);
    assign grant   = (state == ST_IDLE) && arb_valid;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_nxt = ST_WAIT_BUSY;
                cnt_nxt   = '0;
            end
            ST_WAIT_BUSY: begin
                // A falling tx_done beats the watchdog limit in the same cycle.
                if (!tx_done) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (cnt_inc == BUSY_LIM) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_POST;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = ST_POST;
                    cnt_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LIM) state_nxt = ST_IDLE;
                else                cnt_nxt   = cnt_inc;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            tx_start    <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= CH1;
            err_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            busy     <= (state_nxt != ST_IDLE);
            tx_start <= grant;
            ack0     <= grant && (arb_id == CH0);
            ack1     <= grant && (arb_id == CH1);
            if (grant) begin
                grant_id <= arb_id;
                tx_data  <= (arb_id == CH1) ? data1 : data0;
            end
            if (timeout_hit)  err_timeout <= 1'b1;
            else if (clr_err) err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int BT    = 16;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          tx_done = 1'b1;
    logic          ack0, ack1, tx_start, busy, grant_id, err_timeout;
    logic [DW-1:0] tx_data;

    logic          req0_b = 1'b0, req1_b = 1'b0, clr_err_b = 1'b0;
    logic [DW-1:0] data0_b = '0, data1_b = '0;
    logic          tx_done_b = 1'b1;
    logic          ack0_b, ack1_b, tx_start_b, busy_b, grant_id_b, err_timeout_b;
    logic [DW-1:0] tx_data_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cnt_a = 0, cnt_b = 0;
    int lat_a = 2, len_a = 20, lat_b = 1, len_b = 10;
    bit stuck = 1'b0, rand_tx = 1'b0;

    uart_tx_scheduler #(.DATA_W(DW), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout), .clr_err(clr_err)
    );

    uart_tx_scheduler #(.DATA_W(DW), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0_b), .data0(data0_b), .ack0(ack0_b),
        .req1(req1_b), .data1(data1_b), .ack1(ack1_b),
        .tx_done(tx_done_b), .tx_start(tx_start_b), .tx_data(tx_data_b),
        .busy(busy_b), .grant_id(grant_id_b), .err_timeout(err_timeout_b), .clr_err(clr_err_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Tx unit model: tx_done falls lat cycles after tx_start and stays low for len cycles.
    task automatic txm(input logic start, input bit stk, input int lat, input int len,
                       inout int cnt, output logic done);
        if (!reset)               cnt = 0;
        else if (start && !stk)   cnt = lat + len;
        else if (cnt > 0)         cnt--;
        done = !(cnt > 0 && cnt <= len);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rand_tx && tx_start) begin
            lat_a = int'($urandom_range(1, 4));
            len_a = int'($urandom_range(2, 12));
        end
        txm(tx_start,   stuck, lat_a, len_a, cnt_a, tx_done);
        txm(tx_start_b, 1'b0,  lat_b, len_b, cnt_b, tx_done_b);
    endtask

    task automatic wait_start(input string name, output int c);
        int n;
        n = 0;
        c = -1;
        while (c < 0 && n < 300) begin
            tick();
            n++;
            if (tx_start) c = cyc;
        end
        chk({name, "_start"}, 32'(c >= 0), 1);
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0 = 0; req1 = 0; clr_err = 0; req0_b = 0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic          r0;
        logic          r1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          g;
        logic [DW-1:0] d;
    } vec_t;

    vec_t tbl [8];
    bit   h0 [0:3999];
    bit   h1 [0:3999];

    initial begin
        int ls, n, c_req, c_rel, n_start, n_ack0, blen, dbad, idle_c, ac;
        int sa [2];
        int sb [2];
        int na, nb, n0, n1;
        bit ack1_seen;
        logic [DW-1:0] exp_d [4];
        logic          exp_g [4];

        tbl[0] = '{1'b1, 1'b1, 8'hA1, 8'hB2, 1'b1, 8'hB2};
        tbl[1] = '{1'b1, 1'b1, 8'hA3, 8'hB4, 1'b0, 8'hA3};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 8'h77, 1'b1, 8'h77};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h78, 1'b1, 8'h78};
        tbl[4] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11};
        tbl[5] = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 8'h33};
        tbl[6] = '{1'b1, 1'b1, 8'h44, 8'h66, 1'b1, 8'h66};
        tbl[7] = '{1'b1, 1'b0, 8'h5A, 8'h00, 1'b0, 8'h5A};

        // Reset values
        repeat (2) tick();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 1);
        chk("rst_err", err_timeout, 0);
        reset = 1'b1;

        // Single transfer on ch0
        lat_a = 2; len_a = 20;
        chk("single_pre_busy", busy, 0);
        req0 = 1; data0 = 8'h55; c_req = cyc;
        wait_start("single", ls);
        chk("single_latency", ls, c_req + 1);
        chk("single_ack0", ack0, 1);
        chk("single_gid", grant_id, 0);
        req0 = 0;
        n_start = 1; n_ack0 = 1; ack1_seen = ack1; blen = 0; dbad = 0;
        while (busy && blen < 200) begin
            blen++;
            if (tx_data !== 8'h55) dbad++;
            tick();
            n_start += int'(tx_start);
            n_ack0  += int'(ack0);
            ack1_seen |= ack1;
        end
        chk("single_busy_len", blen, 1 + lat_a + len_a + GAP_A);
        chk("single_nstart", n_start, 1);
        chk("single_nack0", n_ack0, 1);
        chk("single_ack1", ack1_seen, 0);
        chk("single_data_stable", dbad, 0);

        // Table of single grants, round-robin state carried from one to the next
        for (int i = 0; i < 8; i++) begin
            req0 = tbl[i].r0; data0 = tbl[i].d0;
            req1 = tbl[i].r1; data1 = tbl[i].d1;
            wait_start("tbl", ls);
            chk("tbl_gid", grant_id, tbl[i].g);
            chk("tbl_data", tx_data, tbl[i].d);
            chk("tbl_ack0", ack0, !tbl[i].g);
            chk("tbl_ack1", ack1, tbl[i].g);
            req0 = 0; req1 = 0;
            wait_idle("tbl", n);
        end

        // Contention right after reset with re-armed requesters
        do_reset();
        exp_d = '{8'hA1, 8'hB2, 8'hA3, 8'hB4};
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        req0 = 1; data0 = 8'hA1; req1 = 1; data1 = 8'hB2; n0 = 0; n1 = 0;
        for (int i = 0; i < 4; i++) begin
            wait_start("cont", ls);
            chk("cont_data", tx_data, exp_d[i]);
            chk("cont_gid", grant_id, exp_g[i]);
            if (ack0) begin n0++; if (n0 == 1) data0 = 8'hA3; else req0 = 0; end
            if (ack1) begin n1++; if (n1 == 1) data1 = 8'hB4; else req1 = 0; end
        end
        req0 = 0; req1 = 0;
        wait_idle("cont", n);

        // Watchdog
        stuck = 1; req1 = 1; data1 = 8'h3C;
        wait_start("wd", ls);
        req1 = 0;
        chk("wd_gid", grant_id, 1);
        repeat (15) tick();
        chk("wd_err_before", err_timeout, 0);
        tick();
        chk("wd_err_rise", err_timeout, 1);
        wait_idle("wd", n);
        stuck = 0;
        req0 = 1; data0 = 8'hC3;
        wait_start("wd_next", ls);
        req0 = 0;
        chk("wd_next_data", tx_data, 8'hC3);
        wait_idle("wd_next", n);
        chk("wd_next_len", n, 1 + lat_a + len_a + GAP_A);
        chk("wd_sticky", err_timeout, 1);
        clr_err = 1;
        tick();
        clr_err = 0;
        chk("wd_clear", err_timeout, 0);
        stuck = 1; req1 = 1; data1 = 8'h5A;
        wait_start("wd2", ls);
        req1 = 0;
        repeat (15) tick();
        chk("wd2_err_before", err_timeout, 0);
        clr_err = 1;
        tick();
        clr_err = 0;
        chk("wd2_set_beats_clr", err_timeout, 1);
        wait_idle("wd2", n);
        stuck = 0;

        // Reset during WAIT_DONE
        req0 = 1; data0 = 8'h99;
        wait_start("rwd", ls);
        req0 = 0;
        repeat (5) tick();
        chk("rwd_busy_before", busy, 1);
        reset = 0; req1 = 1; data1 = 8'hE7;
        #1;
        chk("rwd_tx_start", tx_start, 0);
        chk("rwd_ack", {ack0, ack1}, 0);
        chk("rwd_tx_data", tx_data, 0);
        chk("rwd_busy", busy, 0);
        chk("rwd_gid", grant_id, 1);
        chk("rwd_err", err_timeout, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rwd_quiet", {tx_start, ack0, ack1}, 0);
        end
        reset = 1; c_rel = cyc;
        wait_start("rwd_rel", ls);
        chk("rwd_rel_latency", ls, c_rel + 1);
        chk("rwd_rel_gid", grant_id, 1);
        chk("rwd_rel_data", tx_data, 8'hE7);
        chk("rwd_rel_ack1", ack1, 1);
        req1 = 0;
        wait_idle("rwd_rel", n);
        reset = 0; req0 = 1; data0 = 8'h12; req1 = 1; data1 = 8'h34;
        repeat (2) tick();
        reset = 1;
        wait_start("rwd_both", ls);
        chk("rwd_both_gid", grant_id, 0);
        chk("rwd_both_data", tx_data, 8'h12);
        req0 = 0; req1 = 0;
        wait_idle("rwd_both", n);

        // Back-to-back spacing, GAP_CYCLES=2 (dut_a) vs 0 (dut_b)
        do_reset();
        lat_a = 1; len_a = 10; lat_b = 1; len_b = 10;
        req0 = 1; data0 = 8'h61; req0_b = 1; data0_b = 8'h61;
        na = 0; nb = 0;
        for (int k = 0; k < 100 && (na < 2 || nb < 2); k++) begin
            tick();
            if (tx_start && na < 2) begin
                sa[na] = cyc; na++; data0 = 8'h62;
                if (na == 2) req0 = 0;
            end
            if (tx_start_b && nb < 2) begin
                sb[nb] = cyc; nb++; data0_b = 8'h62;
                if (nb == 2) req0_b = 0;
            end
        end
        chk("gap_na", na, 2);
        chk("gap_nb", nb, 2);
        chk("gap_a_spacing", sa[1] - sa[0], lat_a + len_a + GAP_A + 2);
        chk("gap_b_spacing", sb[1] - sb[0], lat_b + len_b + GAP_B + 2);
        chk("gap_delta", (sa[1] - sa[0]) - (sb[1] - sb[0]), 2);
        wait_idle("gap", n);

        // Late request during WAIT_DONE
        lat_a = 2; len_a = 8;
        req1 = 1; data1 = 8'h21;
        wait_start("late", ls);
        req1 = 0;
        repeat (5) tick();
        req0 = 1; data0 = 8'h42;
        idle_c = -1; ac = -1;
        for (int k = 0; k < 100 && ac < 0; k++) begin
            tick();
            if (!busy && idle_c < 0) idle_c = cyc;
            if (ack0) ac = cyc;
        end
        chk("late_idle_seen", 32'(idle_c >= 0), 1);
        chk("late_ack_cycle", ac, idle_c + 1);
        req0 = 0;
        wait_idle("late", n);

        // Randomized requesters against a frame-level reference
        begin
            int base, idle_from, frames, e, w0, w1;
            logic gid_m, eg, r0, r1;
            bit pend0, pend1;
            logic [DW-1:0] b0, b1;
            do_reset();
            base = cyc; idle_from = cyc; gid_m = CH1; frames = 0;
            pend0 = 0; pend1 = 0; b0 = '0; b1 = '0;
            w0 = int'($urandom_range(0, 5)); w1 = int'($urandom_range(0, 5));
            h0[0] = 0; h1[0] = 0;
            lat_a = 2; len_a = 5; rand_tx = 1;
            for (int k = 0; k < 3000 && frames < 40; k++) begin
                tick();
                if (tx_start) begin
                    frames++;
                    e = idle_from;
                    while (e < cyc && !(h0[e - base] || h1[e - base])) e++;
                    chk("rand_start_cycle", cyc, e + 1);
                    r0 = h0[cyc - 1 - base];
                    r1 = h1[cyc - 1 - base];
                    eg = (r0 && r1) ? !gid_m : r1;
                    chk("rand_gid", grant_id, eg);
                    chk("rand_ack0", ack0, !eg);
                    chk("rand_ack1", ack1, eg);
                    chk("rand_data", tx_data, eg ? b1 : b0);
                    gid_m = eg;
                    idle_from = cyc + lat_a + len_a + GAP_A + 1;
                    if (eg) begin pend1 = 0; w1 = int'($urandom_range(0, 20)); end
                    else    begin pend0 = 0; w0 = int'($urandom_range(0, 20)); end
                end else if (ack0 || ack1) begin
                    chk("rand_stray_ack", {ack0, ack1}, 0);
                end
                if (!pend0) begin
                    if (w0 == 0) begin pend0 = 1; b0 = 8'($urandom); end
                    else w0--;
                end
                if (!pend1) begin
                    if (w1 == 0) begin pend1 = 1; b1 = 8'($urandom); end
                    else w1--;
                end
                req0 = pend0; data0 = pend0 ? b0 : 8'($urandom);
                req1 = pend1; data1 = pend1 ? b1 : 8'($urandom);
                h0[cyc - base] = pend0;
                h1[cyc - base] = pend1;
            end
            rand_tx = 0;
            req0 = 0; req1 = 0;
            chk("rand_frames", frames, 40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
